dwpe_stream: RTL and testbench
==============================

Name: dwpe_stream

Overview:
- Next-generation depthwise-convolution processing element: POX parallel output lanes, each a signed MAC.
- Kernel tap count, bias, requantisation shift and activation are runtime-configurable.
- Accepts one weight tap plus POX pixels per beat over a valid/ready handshake.
- Produces saturated, activated lane results through a registered output stage with backpressure.
- Sits between the line-buffer/weight-fetch logic and the pointwise stage of the accelerator.

Parameters:
- POX, 6, number of parallel output lanes.
- DW, 16, signed pixel/weight width.
- KMAX, 9, maximum taps per window (KSIZE**2).
- AW, 40, signed accumulator width; must be at least 2*DW+$clog2(KMAX).
- OW, 16, signed output lane width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous window abort.
- cfg_taps  in  $clog2(KMAX+1)  taps per window.
- cfg_act  in  2  activation: 00 none, 01 relu, 10 clip, 11 treated as none.
- cfg_clip  in  OW  upper clip bound for mode 10; non-negative.
- cfg_shift  in  $clog2(AW)  arithmetic right shift for requantisation.
- bias  in  AW  signed bias added once per window.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid and in_ready are both high.
- in_pix  in  POX*DW  signed pixels; lane i at [i*DW +: DW].
- in_wt  in  DW  signed weight tap shared by all lanes.
- out_valid  out  1  result register holds an unconsumed window.
- out_ready  in  1  consumer accepts the window.
- out_data  out  POX*OW  signed lane results; lane i at [i*OW +: OW].
- busy  out  1  window in progress (tap_cnt != 0).

Behaviour:
- Reset (async, rst_n low): tap_cnt=0, all accumulators 0, out_valid=0, out_data=0, busy=0. in_ready goes high once reset is released.
- Config latch: cfg_taps, cfg_act, cfg_clip, cfg_shift and bias are sampled on the first accepted beat of each window (tap_cnt==0) and held until the window completes. Changes mid-window have no effect.
- Effective taps: cfg_taps==0 means 1; cfg_taps>KMAX means KMAX.
- Accumulate: on each accepted beat, prod_i = in_pix_i * in_wt, full 2*DW signed.
  - First tap: acc_i <= sext(prod_i).
  - Otherwise: acc_i <= acc_i + prod_i, wrapping at AW bits.
  - tap_cnt increments on every accepted beat.
- Final tap: the beat accepted with tap_cnt==taps-1.
  - On the same edge, the output register loads post(acc_i + prod_i), out_valid is set, and tap_cnt returns to 0.
  - Latency: out_valid rises on the edge that accepts the final beat, so it is visible in the following cycle.
- Post-processing, per lane:
  - s = acc + bias_latched.
  - If shift>0: r = (s + (1<<(shift-1))) >>> shift, i.e. round half toward +inf. If shift==0: r = s.
  - relu: r<0 gives 0.
  - clip: result is r clamped to [0, cfg_clip].
  - Finally saturate to the signed OW range [-2^(OW-1), 2^(OW-1)-1].
- Output handshake:
  - out_valid clears on the edge where out_valid && out_ready, unless a new final beat loads on that same edge, in which case it stays 1.
  - out_data is stable while out_valid && !out_ready.
- in_ready = !(tap_cnt==taps_eff-1 && out_valid && !out_ready).
  - Non-final beats are never stalled; only the final beat waits for the output register to free.
  - For the first beat, taps_eff is taken from the live cfg_taps.
- clr: synchronous, highest priority over beat acceptance. Sets tap_cnt=0 and accumulators=0, and the beat presented in that cycle is dropped. It does not touch out_valid or out_data.
- Async reset mid-window discards everything; the next window after reset must be computed correctly.

Test Plan:
- Nominal window: taps=9, wt=3 on every beat, lane i pixel on beat j = i+j, bias=0, shift=0, act=none, out_ready=1 → lane i = 27i+108 (lane0=108, lane5=243); out_valid high in the cycle after the 9th beat, for one cycle.
- Backpressure: two back-to-back windows with out_ready=0 → in_ready low only when the 2nd window's 9th beat is presented; after a single out_ready pulse, the 1st result is consumed, the 2nd loads on the same edge with out_valid staying 1, and no beat is lost or duplicated.
- Activation: taps=4, pix=100, wt=-1 → none gives -400, relu gives 0; pix=100, wt=1, clip with cfg_clip=50 gives 50; bias=+500 with wt=-1 and none gives 100.
- Rounding/saturation: pix=32767, wt=32767, taps=9, shift=0 → 32767 all lanes. Window sum 3 with shift=1 → 2; sum -3 with shift=1 → -1; pix=-32768, wt=32767, taps=9 → -32768.
- Config bounds: cfg_taps=0 → every beat is a full window; cfg_taps=15 → 9-beat windows; cfg_taps changed from 9 to 4 at beat 3 → the window still closes after 9 beats, the next window uses 4.
- Abort/reset: clr asserted at beat 5 → partial window discarded, the next full window gives the nominal values with a pending out_data unchanged; rst_n low at beat 4 → all outputs 0 immediately, and a subsequent window is correct.

Source files
------------

// File: rtl/dwpe_stream.sv
// dwpe_stream: depthwise-convolution processing element.
// POX signed MAC lanes share one weight tap per beat; a window of taps is
// accumulated, then biased, rounded, activated and saturated into a
// registered output stage with valid/ready backpressure.
module dwpe_stream #(
  parameter  int POX  = 6,
  parameter  int DW   = 16,
  parameter  int KMAX = 9,
  parameter  int AW   = 40,
  parameter  int OW   = 16,
  localparam int TW   = $clog2(KMAX + 1),
  localparam int SW   = $clog2(AW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [TW-1:0]     cfg_taps,
  input  logic [1:0]        cfg_act,
  input  logic [OW-1:0]     cfg_clip,
  input  logic [SW-1:0]     cfg_shift,
  input  logic [AW-1:0]     bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POX*DW-1:0] in_pix,
  input  logic [DW-1:0]     in_wt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [POX*OW-1:0] out_data,
  output logic              busy
);

  // Post-processing runs in AW+2 bits so bias add and rounding never wrap.
  localparam int PW = AW + 2;

  logic [TW-1:0]        tap_cnt;
  logic [TW-1:0]        taps_l;
  logic [1:0]           act_l;
  logic [OW-1:0]        clip_l;
  logic [SW-1:0]        shift_l;
  logic signed [AW-1:0] bias_l;
  logic signed [AW-1:0] acc [POX];
  logic                 ready_en;

  logic                 first;
  logic [TW-1:0]        taps_eff;
  logic                 last_beat;
  logic                 accept;
  logic [1:0]           cur_act;
  logic [OW-1:0]        cur_clip;
  logic [SW-1:0]        cur_shift;
  logic signed [AW-1:0] cur_bias;
  logic signed [DW-1:0]   pix  [POX];
  logic signed [2*DW-1:0] prod [POX];
  logic signed [AW-1:0]   sum  [POX];
  logic [POX*OW-1:0]      post_data;

  // 0 taps means a single-tap window; anything above KMAX is clamped.
  function automatic logic [TW-1:0] eff_taps(input logic [TW-1:0] t);
    if (t == '0)                 return TW'(1);
    else if (t > TW'(KMAX))      return TW'(KMAX);
    else                         return t;
  endfunction

  // Bias, round-half-up shift, activation and OW-bit saturation for one lane.
  function automatic logic [OW-1:0] post_proc(
    input logic signed [AW-1:0] a,
    input logic signed [AW-1:0] b,
    input logic [SW-1:0]        sh,
    input logic [1:0]           act,
    input logic [OW-1:0]        clip
  );
    logic signed [PW-1:0] s;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] r;
    logic signed [PW-1:0] cx;
    logic signed [PW-1:0] maxv;
    logic signed [PW-1:0] minv;
    s    = PW'(a) + PW'(b);
    rnd  = '0;
    if (sh != '0) rnd = PW'(1) << (sh - SW'(1));
    r    = (s + rnd) >>> sh;
    cx   = {{(PW-OW){1'b0}}, clip};
    maxv = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    minv = ~maxv;
    if (act == 2'b01 && r < 0) r = '0;
    if (act == 2'b10) begin
      if (r < 0)       r = '0;
      else if (r > cx) r = cx;
    end
    if (r > maxv)      r = maxv;
    else if (r < minv) r = minv;
    return r[OW-1:0];
  endfunction

  // Window position, live-vs-latched config selection and the handshake.
  always_comb begin
    first     = (tap_cnt == '0);
    taps_eff  = first ? eff_taps(cfg_taps) : taps_l;
    last_beat = (tap_cnt == taps_eff - TW'(1));
    cur_act   = first ? cfg_act   : act_l;
    cur_clip  = first ? cfg_clip  : clip_l;
    cur_shift = first ? cfg_shift : shift_l;
    cur_bias  = first ? $signed(bias) : bias_l;
    in_ready  = ready_en && !(last_beat && out_valid && !out_ready);
    accept    = in_valid && in_ready && !clr;
    busy      = !first;
  end

  // Per-lane product, running sum and post-processed result of the final tap.
  always_comb begin
    post_data = '0;
    for (int i = 0; i < POX; i++) begin
      pix[i]  = $signed(in_pix[i*DW +: DW]);
      prod[i] = pix[i] * $signed(in_wt);
      sum[i]  = (first ? AW'(0) : acc[i]) +
                {{(AW-2*DW){prod[i][2*DW-1]}}, prod[i]};
      post_data[i*OW +: OW] = post_proc(sum[i], cur_bias, cur_shift, cur_act, cur_clip);
    end
  end

  // Hold off in_ready until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Tap counter, accumulators and per-window configuration latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt <= '0;
      taps_l  <= '0;
      act_l   <= '0;
      clip_l  <= '0;
      shift_l <= '0;
      bias_l  <= '0;
      for (int i = 0; i < POX; i++) acc[i] <= '0;
    end else if (clr) begin
      tap_cnt <= '0;
      for (int i = 0; i < POX; i++) acc[i] <= '0;
    end else if (accept) begin
      if (first) begin
        taps_l  <= eff_taps(cfg_taps);
        act_l   <= cfg_act;
        clip_l  <= cfg_clip;
        shift_l <= cfg_shift;
        bias_l  <= $signed(bias);
      end
      for (int i = 0; i < POX; i++) acc[i] <= sum[i];
      tap_cnt <= last_beat ? '0 : tap_cnt + TW'(1);
    end
  end

  // Output register: a new result may load on the same edge the old one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && last_beat) begin
      out_valid <= 1'b1;
      out_data  <= post_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dwpe_stream.sv
// tb_dwpe_stream: directed self-checking bench for dwpe_stream.
module tb_dwpe_stream;

  localparam int POX  = 6;
  localparam int DW   = 16;
  localparam int KMAX = 9;
  localparam int AW   = 40;
  localparam int OW   = 16;
  localparam int TW   = $clog2(KMAX + 1);
  localparam int SW   = $clog2(AW);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [TW-1:0]     cfg_taps;
  logic [1:0]        cfg_act;
  logic [OW-1:0]     cfg_clip;
  logic [SW-1:0]     cfg_shift;
  logic [AW-1:0]     bias;
  logic              in_valid;
  logic              in_ready;
  logic [POX*DW-1:0] in_pix;
  logic [DW-1:0]     in_wt;
  logic              out_valid;
  logic              out_ready;
  logic [POX*OW-1:0] out_data;
  logic              busy;

  int testsRun    = 0;
  int testsFailed = 0;
  int stallCycles = 0;

  dwpe_stream #(.POX(POX), .DW(DW), .KMAX(KMAX), .AW(AW), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .cfg_taps(cfg_taps), .cfg_act(cfg_act), .cfg_clip(cfg_clip),
    .cfg_shift(cfg_shift), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_wt(in_wt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint lane(input int i);
    logic signed [OW-1:0] v;
    v = out_data[i*OW +: OW];
    return longint'(v);
  endfunction

  function automatic logic [POX*DW-1:0] mkPix(input int base, input int lstep);
    logic [POX*DW-1:0] v;
    for (int i = 0; i < POX; i++) v[i*DW +: DW] = DW'(base + lstep * i);
    return v;
  endfunction

  // One beat: present at negedge, wait (bounded) for in_ready, return after the accepting edge.
  task automatic applyStimulus(input logic [POX*DW-1:0] pix, input int wt);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_pix   = pix;
    in_wt    = DW'(wt);
    budget   = 0;
    while (!in_ready && budget < 50) begin
      stallCycles++;
      budget++;
      @(negedge clk);
    end
    if (budget >= 50) checkOutput("beat_stall_timeout", 0, 1);
    @(posedge clk);
  endtask

  // Beat j carries lane i pixel = base + jstep*j + lstep*i.
  task automatic runBeats(input int n, input int base, input int jstep, input int lstep, input int wt);
    for (int j = 0; j < n; j++) applyStimulus(mkPix(base + jstep * j, lstep), wt);
  endtask

  task automatic finishWindow();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkLanes(input string tag, input longint e0, input longint step);
    checkOutput({tag, "_valid"}, out_valid, 1);
    for (int i = 0; i < POX; i++)
      checkOutput($sformatf("%s_lane%0d", tag, i), lane(i), e0 + step * i);
  endtask

  task automatic runWindow(input string tag, input int n, input int base, input int jstep,
                           input int lstep, input int wt, input longint e0, input longint step);
    runBeats(n, base, jstep, lstep, wt);
    finishWindow();
    checkLanes(tag, e0, step);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_pix = '0; in_wt = '0;
    cfg_taps = TW'(9); cfg_act = 2'b00; cfg_clip = '0; cfg_shift = '0; bias = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_data", (out_data == '0), 1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);

    // Nominal 9-tap window
    for (int j = 0; j < 9; j++) begin
      applyStimulus(mkPix(j, 1), 3);
      #1;
      if (j == 0) checkOutput("nom_busy", busy, 1);
      if (j == 7) checkOutput("nom_early_valid", out_valid, 0);
    end
    finishWindow();
    checkLanes("nom", 108, 27);
    @(negedge clk);
    checkOutput("nom_one_cycle", out_valid, 0);

    // Activation modes, 4 taps
    cfg_taps = TW'(4);
    runWindow("act_none", 4, 100, 0, 0, -1, -400, 0);
    cfg_act = 2'b01;
    runWindow("act_relu", 4, 100, 0, 0, -1, 0, 0);
    cfg_act = 2'b10; cfg_clip = OW'(50);
    runWindow("act_clip", 4, 100, 0, 0, 1, 50, 0);
    cfg_act = 2'b00; bias = AW'(500);
    runWindow("act_bias", 4, 100, 0, 0, -1, 100, 0);
    bias = '0;

    // Saturation and rounding
    cfg_taps = TW'(9);
    runWindow("sat_pos", 9, 32767, 0, 0, 32767, 32767, 0);
    runWindow("sat_neg", 9, -32768, 0, 0, 32767, -32768, 0);
    cfg_taps = TW'(3); cfg_shift = SW'(1);
    runWindow("rnd_pos", 3, 1, 0, 0, 1, 2, 0);
    runWindow("rnd_neg", 3, -1, 0, 0, 1, -1, 0);
    cfg_shift = '0;

    // Tap-count bounds
    cfg_taps = TW'(0);
    runWindow("taps0_a", 1, 5, 0, 0, 2, 10, 0);
    runWindow("taps0_b", 1, 7, 0, 0, 3, 21, 0);
    cfg_taps = TW'(15);
    runWindow("taps15", 9, 1, 0, 0, 1, 9, 0);

    // Mid-window cfg_taps change is ignored
    cfg_taps = TW'(9);
    for (int j = 0; j < 9; j++) begin
      if (j == 3) cfg_taps = TW'(4);
      applyStimulus(mkPix(1, 0), 1);
      #1;
      if (j == 3) checkOutput("cfgchg_no_early", out_valid, 0);
    end
    finishWindow();
    checkLanes("cfgchg_9", 9, 0);
    runWindow("cfgchg_4", 4, 1, 0, 0, 1, 4, 0);

    // Backpressure across two back-to-back windows
    cfg_taps = TW'(9);
    @(negedge clk);
    out_ready = 1'b0;
    runBeats(9, 0, 1, 1, 3);
    stallCycles = 0;
    runBeats(8, 1, 0, 0, 1);
    checkOutput("bp_no_stall", stallCycles, 0);
    @(negedge clk);
    in_valid = 1'b1; in_pix = mkPix(1, 0); in_wt = DW'(1);
    #1;
    checkOutput("bp_ready_low", in_ready, 0);
    checkOutput("bp_hold_lane0", lane(0), 108);
    @(negedge clk);
    checkOutput("bp_ready_low2", in_ready, 0);
    checkOutput("bp_hold_lane5", lane(5), 243);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_ready_high", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    checkLanes("bp_second", 9, 0);
    checkOutput("bp_idle", busy, 0);
    @(negedge clk);
    checkOutput("bp_held_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_drained", out_valid, 0);

    // Abort with clr while a result is pending
    out_ready = 1'b0;
    runWindow("clr_pending", 9, 2, 0, 0, 1, 18, 0);
    runBeats(5, 50, 0, 0, 1);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_pix = mkPix(77, 0); in_wt = DW'(1);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_keep_valid", out_valid, 1);
    checkOutput("clr_keep_lane0", lane(0), 18);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("clr_drained", out_valid, 0);
    runWindow("clr_next", 9, 0, 1, 1, 3, 108, 27);

    // Async reset in the middle of a window
    runBeats(4, 0, 1, 1, 3);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_valid", out_valid, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_lane0", lane(0), 0);
    checkOutput("mrst_lane5", lane(5), 0);
    @(negedge clk);
    rst_n = 1'b1;
    runWindow("mrst_next", 9, 0, 1, 1, 3, 108, 27);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
